audio_out_feeder: RTL and testbench
===================================

AUDIO_OUT_FEEDER -- requirements
Module: audio_out_feeder

Interface
REQ-001 SHALL have parameter DEPTH, default 8, meaning FIFO entries (power of two, 2..64).
REQ-002 SHALL have port clk_50 input 1: system clock; all logic on its rising edge.
REQ-003 SHALL have port rst input 1: reset, synchronous, active-high; clock clk_50.
REQ-004 SHALL have port sample_in input 16: signed PCM sample from the flash music fetch stage.
REQ-005 SHALL have port sample_valid input 1: one-cycle strobe, sample_in valid.
REQ-006 SHALL have port sample_ready output 1: high when FIFO count < DEPTH.
REQ-007 SHALL have port audio_out_allowed input 1: codec output FIFO has space.
REQ-008 SHALL have port write_audio_out output 1: one-cycle codec write strobe.
REQ-009 SHALL have ports writedata_left and writedata_right output 16: processed sample, both channels identical.
REQ-010 SHALL have port volume_shift input 3: arithmetic right-shift amount, 0..7.
REQ-011 SHALL have port mute input 1: force output samples to zero.
REQ-012 SHALL have port fill_level output $clog2(DEPTH)+1: current FIFO count.
REQ-013 SHALL have port overflow output 1: sticky dropped-sample flag.
REQ-014 SHALL have port underflow_count output 16: saturating starvation-event counter.

Function
REQ-015 SHALL store samples in a circular FIFO with read/write pointers wrapping at DEPTH and a count of 0..DEPTH.
REQ-016 SHALL push sample_in when sample_valid is high and count < DEPTH, or when count == DEPTH and a pop occurs in the same cycle.
REQ-017 SHALL drop sample_valid with FIFO full and no same-cycle pop, and set overflow to 1 until reset.
REQ-018 SHALL leave count unchanged on a simultaneous push and pop.
REQ-019 SHALL use FSM states IDLE and WRITE: IDLE -> WRITE when audio_out_allowed and count > 0 (pop head); WRITE -> IDLE unconditionally.
REQ-020 SHALL register writedata_left/right on the IDLE -> WRITE edge and hold them until the next pop.
REQ-021 SHALL drive write_audio_out high only while in WRITE, for exactly one cycle per popped sample, giving at most one sample per 2 cycles.
REQ-022 SHALL compute the output as popped sample arithmetic-shifted right by volume_shift (sign preserved), or 16'h0000 when mute is high, sampled at pop time.
REQ-023 SHALL have latency: sample_valid at edge N into an empty FIFO with audio_out_allowed high -> write_audio_out high in the cycle after edge N+1.
REQ-024 SHALL increment underflow_count once per rising edge of the condition (IDLE, audio_out_allowed high, count == 0), saturating at 16'hFFFF.
REQ-025 SHALL make audio_out_allowed falling while in WRITE have no effect on the current strobe.

Reset
REQ-026 SHALL on rst: state IDLE, pointers and count 0, write_audio_out 0, writedata_left/right 16'h0000, overflow 0, underflow_count 0, sample_ready 1.
REQ-027 SHALL on rst mid-operation discard all FIFO contents and any sample_valid in the same cycle.

Structure
REQ-028 SHALL place the FSM state enum, sample width (16) and default DEPTH in shared package audio_pkg.
REQ-029 SHALL implement storage as sub-module sample_fifo (push, pop, data, count), with the FSM and processing in audio_out_feeder.

Verification
REQ-030 SHALL cover this scenario: push 16'h4000, allowed=1, shift=0, mute=0 -> one write_audio_out strobe two edges later, left=right=16'h4000.
REQ-031 SHALL cover this scenario: push 16'h8000, shift=3 -> output 16'hF000; the same sample with mute=1 -> 16'h0000.
REQ-032 SHALL cover this scenario: allowed=0, push 9 samples with DEPTH=8 -> fill_level 8, sample_ready 0, overflow 1, ninth sample absent from output.
REQ-033 SHALL cover this scenario: FIFO full plus simultaneous push and pop -> push accepted, fill_level stays 8, overflow stays 0.
REQ-034 SHALL cover this scenario: allowed=1 and FIFO empty for 3 separate intervals -> underflow_count 3; force the 16'hFFFF case -> holds 16'hFFFF.
REQ-035 SHALL cover this scenario: rst asserted with fill_level 5 -> next cycle fill_level 0, outputs zero, no write strobe.

Source files
------------

// File: rtl/audio_pkg.sv
// -----------------------------------------------------------------------------
// audio_pkg
// Shared definitions for the audio output path: sample width, default FIFO
// depth, the feeder FSM state type and the volume/mute sample processing.
// -----------------------------------------------------------------------------
package audio_pkg;

    localparam int SAMPLE_W      = 16;
    localparam int SHIFT_W       = 3;
    localparam int DEFAULT_DEPTH = 8;

    typedef logic signed [SAMPLE_W-1:0] sample_t;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_WRITE = 1'b1
    } feeder_state_e;

    // Attenuate by an arithmetic right shift (sign preserved), or silence.
    function automatic sample_t process_sample(input sample_t             s,
                                               input logic [SHIFT_W-1:0] shift,
                                               input logic               mute);
        if (mute) begin
            return '0;
        end
        return s >>> shift;
    endfunction

endpackage

// File: rtl/audio_out_feeder_sample_fifo.sv
// -----------------------------------------------------------------------------
// sample_fifo
// Circular sample buffer with wrapping read/write pointers and an occupancy
// count of 0..DEPTH. The caller guarantees push/pop legality.
//   clk_50  : clock, rising edge
//   rst     : synchronous active-high reset (pointers and count to zero)
//   push_i  : write data_i at the tail
//   pop_i   : advance the head
//   data_i  : sample to store
//   data_o  : sample currently at the head
//   count_o : number of stored samples
// -----------------------------------------------------------------------------
module sample_fifo
    import audio_pkg::*;
#(
    parameter int DEPTH = DEFAULT_DEPTH
) (
    input  logic                     clk_50,
    input  logic                     rst,
    input  logic                     push_i,
    input  logic                     pop_i,
    input  logic [SAMPLE_W-1:0]      data_i,
    output logic [SAMPLE_W-1:0]      data_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int AW = $clog2(DEPTH);

    logic [SAMPLE_W-1:0] mem_q [DEPTH];
    logic [AW-1:0]       wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]       rd_ptr_q, rd_ptr_d;
    logic [AW:0]         count_q,  count_d;

    // NOTE: the storage array has no reset; pointers and count alone decide
    // which entries are valid, so clearing the array would only cost logic.
    always_ff @(posedge clk_50) begin
        if (push_i) begin
            mem_q[wr_ptr_q] <= data_i;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_i) wr_ptr_d = wr_ptr_q + 1'b1;
        if (pop_i)  rd_ptr_d = rd_ptr_q + 1'b1;
        if (push_i && !pop_i) count_d = count_q + 1'b1;
        if (pop_i && !push_i) count_d = count_q - 1'b1;
    end

    // NOTE: sequential state is updated with non-blocking assignments only, so
    // every register samples its _d value from before the clock edge.
    always_ff @(posedge clk_50) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign data_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;

endmodule

// File: rtl/audio_out_feeder.sv
// -----------------------------------------------------------------------------
// audio_out_feeder
// Buffers PCM samples from the flash fetch stage and feeds them to the codec
// output FIFO, one write strobe per sample, with volume shift and mute.
//   clk_50            : system clock, rising edge
//   rst               : synchronous active-high reset
//   sample_in/_valid  : incoming signed sample and its one-cycle strobe
//   sample_ready      : FIFO has room
//   audio_out_allowed : codec FIFO has space
//   write_audio_out   : one-cycle codec write strobe
//   writedata_left/right : processed sample (identical channels)
//   volume_shift/mute : attenuation controls, sampled when a sample is popped
//   fill_level        : FIFO occupancy
//   overflow          : sticky flag, a sample was dropped on a full FIFO
//   underflow_count   : saturating count of starvation events
// -----------------------------------------------------------------------------
module audio_out_feeder
    import audio_pkg::*;
#(
    parameter int DEPTH = DEFAULT_DEPTH
) (
    input  logic                     clk_50,
    input  logic                     rst,
    input  logic [SAMPLE_W-1:0]      sample_in,
    input  logic                     sample_valid,
    output logic                     sample_ready,
    input  logic                     audio_out_allowed,
    output logic                     write_audio_out,
    output logic [SAMPLE_W-1:0]      writedata_left,
    output logic [SAMPLE_W-1:0]      writedata_right,
    input  logic [SHIFT_W-1:0]       volume_shift,
    input  logic                     mute,
    output logic [$clog2(DEPTH):0]   fill_level,
    output logic                     overflow,
    output logic [15:0]              underflow_count
);

    localparam int                 CW      = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0]      DEPTH_C = CW'(DEPTH);

    feeder_state_e        state_q,  state_d;
    logic [SAMPLE_W-1:0]  wdata_q,  wdata_d;
    logic                 overflow_q, overflow_d;
    logic                 starve_q, starve_d;
    logic [15:0]          underflow_count_q, underflow_count_d;

    logic                 push, pop, full;
    logic [SAMPLE_W-1:0]  head;
    logic [CW-1:0]        count;

    sample_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk_50  (clk_50),
        .rst     (rst),
        .push_i  (push),
        .pop_i   (pop),
        .data_i  (sample_in),
        .data_o  (head),
        .count_o (count)
    );

    assign full = (count == DEPTH_C);
    assign pop  = (state_q == ST_IDLE) && audio_out_allowed && (count != '0);
    // A full FIFO still accepts a sample when the head leaves in the same cycle.
    assign push = sample_valid && (!full || pop);

    // NOTE: every always_comb output gets a default first, so no path through
    // the block can leave a signal unassigned and infer a latch.
    always_comb begin
        state_d           = state_q;
        wdata_d           = wdata_q;
        overflow_d        = overflow_q || (sample_valid && !push);
        // Starvation: ready to send, codec has room, nothing buffered.
        starve_d          = (state_q == ST_IDLE) && audio_out_allowed && (count == '0);
        underflow_count_d = underflow_count_q;

        unique case (state_q)
            ST_IDLE: begin
                if (pop) begin
                    state_d = ST_WRITE;
                    wdata_d = process_sample(sample_t'(head), volume_shift, mute);
                end
            end
            ST_WRITE: begin
                // The strobe is already committed; audio_out_allowed is ignored.
                state_d = ST_IDLE;
            end
        endcase

        // Count rising edges of the starvation condition only.
        if (starve_d && !starve_q && (underflow_count_q != 16'hFFFF)) begin
            underflow_count_d = underflow_count_q + 16'd1;
        end
    end

    always_ff @(posedge clk_50) begin
        if (rst) begin
            state_q           <= ST_IDLE;
            wdata_q           <= '0;
            overflow_q        <= 1'b0;
            starve_q          <= 1'b0;
            underflow_count_q <= '0;
        end else begin
            state_q           <= state_d;
            wdata_q           <= wdata_d;
            overflow_q        <= overflow_d;
            starve_q          <= starve_d;
            underflow_count_q <= underflow_count_d;
        end
    end

    assign sample_ready    = !full;
    assign write_audio_out = (state_q == ST_WRITE);
    assign writedata_left  = wdata_q;
    assign writedata_right = wdata_q;
    assign fill_level      = count;
    assign overflow        = overflow_q;
    assign underflow_count = underflow_count_q;

endmodule

// File: tb/tb_audio_out_feeder.sv
// -----------------------------------------------------------------------------
// tb_audio_out_feeder
// Drives audio_out_feeder with directed scenarios and random traffic and
// compares every output each cycle against a queue-based reference model.
// -----------------------------------------------------------------------------
module tb_audio_out_feeder;

    localparam int DEPTH = 8;

    logic        clk_50 = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] sample_in = '0;
    logic        sample_valid = 1'b0;
    logic        sample_ready;
    logic        audio_out_allowed = 1'b0;
    logic        write_audio_out;
    logic [15:0] writedata_left, writedata_right;
    logic [2:0]  volume_shift = '0;
    logic        mute = 1'b0;
    logic [3:0]  fill_level;
    logic        overflow;
    logic [15:0] underflow_count;

    audio_out_feeder #(.DEPTH(DEPTH)) dut (
        .clk_50            (clk_50),
        .rst               (rst),
        .sample_in         (sample_in),
        .sample_valid      (sample_valid),
        .sample_ready      (sample_ready),
        .audio_out_allowed (audio_out_allowed),
        .write_audio_out   (write_audio_out),
        .writedata_left    (writedata_left),
        .writedata_right   (writedata_right),
        .volume_shift      (volume_shift),
        .mute              (mute),
        .fill_level        (fill_level),
        .overflow          (overflow),
        .underflow_count   (underflow_count)
    );

    always #10 clk_50 = ~clk_50;

    int n_compared = 0;
    int n_mismatch = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_compared++;
        if (got !== exp) begin
            n_mismatch++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // ---------------- reference model ----------------
    logic [15:0] mq[$];       // buffered samples, oldest first
    bit          m_busy;      // a codec strobe is being issued this cycle
    logic [15:0] m_wd;
    bit          m_ovf;
    int          m_uf;
    bit          m_prev_starve;

    // Floor division by 2^sh, i.e. attenuation rounding toward minus infinity.
    function automatic logic [15:0] expect_out(input logic [15:0] s, input int sh, input bit mu);
        int v, p;
        if (mu) return 16'h0000;
        v = int'($signed(s));
        p = 1 << sh;
        if (v < 0) v = -((-v + p - 1) / p);
        else       v = v / p;
        return v[15:0];
    endfunction

    task automatic compare_all(input string ph);
        check({ph, ".wr"},    32'(write_audio_out), 32'(m_busy));
        check({ph, ".left"},  32'(writedata_left),  32'(m_wd));
        check({ph, ".right"}, 32'(writedata_right), 32'(m_wd));
        check({ph, ".fill"},  32'(fill_level),      32'(mq.size()));
        check({ph, ".ready"}, 32'(sample_ready),    32'(mq.size() < DEPTH));
        check({ph, ".ovf"},   32'(overflow),        32'(m_ovf));
        check({ph, ".uf"},    32'(underflow_count), 32'(m_uf));
    endtask

    // One clock: apply inputs (called at a negedge), advance the model,
    // then compare at the following negedge.
    task automatic cycle(input string ph, input bit r, input bit v, input logic [15:0] d,
                         input bit al, input int sh, input bit mu);
        bit pop, starve, acc;
        logic [15:0] head;
        rst = r; sample_valid = v; sample_in = d;
        audio_out_allowed = al; volume_shift = 3'(sh); mute = mu;
        if (r) begin
            mq.delete();
            m_busy = 0; m_wd = '0; m_ovf = 0; m_uf = 0; m_prev_starve = 0;
        end else begin
            pop    = !m_busy && al && (mq.size() > 0);
            starve = !m_busy && al && (mq.size() == 0);
            acc    = v && ((mq.size() < DEPTH) || pop);
            if (pop) begin
                head = mq.pop_front();
                m_wd = expect_out(head, sh, mu);
            end
            if (acc) mq.push_back(d);
            if (v && !acc) m_ovf = 1;
            if (starve && !m_prev_starve && m_uf < 32'hFFFF) m_uf++;
            m_prev_starve = starve;
            m_busy = pop;
        end
        @(posedge clk_50);
        @(negedge clk_50);
        compare_all(ph);
    endtask

    task automatic idle(input string ph, input int n, input bit al, input int sh);
        for (int i = 0; i < n; i++) cycle(ph, 0, 0, 16'h0, al, sh, 0);
    endtask

    initial begin
        @(negedge clk_50);

        // Reset state
        cycle("rst", 1, 0, 16'h0, 0, 0, 0);
        check("rst.ready_const", 32'(sample_ready), 32'd1);
        check("rst.fill_const",  32'(fill_level),   32'd0);

        // Single sample: strobe in the cycle after the second edge
        cycle("lat", 0, 1, 16'h4000, 1, 0, 0);
        check("lat.no_wr_yet", 32'(write_audio_out), 32'd0);
        cycle("lat", 0, 0, 16'h0, 1, 0, 0);
        check("lat.wr",   32'(write_audio_out), 32'd1);
        check("lat.data", 32'(writedata_left),  32'h4000);
        cycle("lat", 0, 0, 16'h0, 1, 0, 0);
        check("lat.one_strobe", 32'(write_audio_out), 32'd0);

        // Volume shift keeps the sign; mute forces zero
        cycle("shf", 0, 1, 16'h8000, 1, 3, 0);
        idle("shf", 1, 1, 3);
        check("shf.data", 32'(writedata_right), 32'hF000);
        idle("shf", 1, 1, 3);
        cycle("mut", 0, 1, 16'h8000, 1, 3, 1);
        cycle("mut", 0, 0, 16'h0, 1, 3, 1);
        check("mut.data", 32'(writedata_left), 32'h0000);
        idle("mut", 2, 1, 0);

        // Overfill with the codec blocked: ninth sample dropped
        cycle("ovf", 1, 0, 16'h0, 0, 0, 0);
        for (int i = 0; i < 9; i++) cycle("ovf", 0, 1, 16'(16'h0100 + i), 0, 0, 0);
        check("ovf.fill",  32'(fill_level),   32'd8);
        check("ovf.ready", 32'(sample_ready), 32'd0);
        check("ovf.flag",  32'(overflow),     32'd1);
        idle("ovf_drain", 20, 1, 0);
        check("ovf.last_out", 32'(writedata_left), 32'h0107);

        // Full FIFO with a simultaneous push and pop
        cycle("fpp", 1, 0, 16'h0, 0, 0, 0);
        for (int i = 0; i < 8; i++) cycle("fpp", 0, 1, 16'(16'h0200 + i), 0, 0, 0);
        cycle("fpp", 0, 1, 16'h1234, 1, 0, 0);
        check("fpp.fill", 32'(fill_level), 32'd8);
        check("fpp.ovf",  32'(overflow),   32'd0);
        idle("fpp_drain", 20, 1, 1);

        // Three separate starvation intervals
        cycle("udf", 1, 0, 16'h0, 0, 0, 0);
        for (int k = 0; k < 3; k++) begin
            idle("udf", 2, 1, 0);
            idle("udf", 1, 0, 0);
        end
        check("udf.count3", 32'(underflow_count), 32'd3);

        // Saturation: preload the counter just below the limit
        force dut.underflow_count_q = 16'hFFFE;
        m_uf = 32'hFFFE;
        idle("sat_hold", 2, 0, 0);
        release dut.underflow_count_q;
        for (int k = 0; k < 3; k++) begin
            idle("sat", 1, 1, 0);
            idle("sat", 1, 0, 0);
        end
        check("sat.count", 32'(underflow_count), 32'hFFFF);

        // Reset in the middle of operation, with a sample offered in that cycle
        cycle("mrs", 1, 0, 16'h0, 0, 0, 0);
        for (int i = 0; i < 6; i++) cycle("mrs", 0, 1, 16'(16'h1111 * (i + 1)), 0, 0, 0);
        cycle("mrs", 0, 0, 16'h0, 1, 0, 0);
        cycle("mrs", 0, 0, 16'h0, 0, 0, 0);
        check("mrs.fill5", 32'(fill_level),     32'd5);
        check("mrs.data",  32'(writedata_left), 32'h1111);
        cycle("mrs", 1, 1, 16'hBEEF, 1, 0, 0);
        check("mrs.fill0", 32'(fill_level),      32'd0);
        check("mrs.wd0",   32'(writedata_left),  32'h0000);
        check("mrs.wr0",   32'(write_audio_out), 32'd0);

        // Random traffic
        for (int i = 0; i < 800; i++) begin
            cycle("rnd",
                  ($urandom_range(0, 99) == 0),
                  ($urandom_range(0, 99) < 60),
                  16'($urandom),
                  ($urandom_range(0, 99) < 45),
                  int'($urandom_range(0, 7)),
                  ($urandom_range(0, 9) == 0));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatch);
        $finish;
    end

endmodule
